// File: rtl/fwd_source_if.sv
// Bypass-producer bundle: issue fields, execute/memory data and controls in, three forwarding tuples out.
// Latency: wires only; all timing belongs to the module on the slave side.
// Backpressure: the producer raises m_wait while a load in memory has no data yet.
interface fwd_source_if;
   typedef struct packed {
      logic [4:0]  dst;
      logic [63:0] data;
      logic        ismem;
   } tran_t;

   logic        issue_valid;
   logic [4:0]  issue_dst;
   logic        issue_wen;
   logic        issue_ismem;
   logic [63:0] alu_data;
   logic [63:0] mem_rdata;
   logic        mem_rvalid;
   logic        stall;
   logic        flush;
   tran_t       trane;
   tran_t       tranm;
   tran_t       tranw;
   logic        m_wait;

   modport master (
      output issue_valid, issue_dst, issue_wen, issue_ismem,
      output alu_data, mem_rdata, mem_rvalid, stall, flush,
      input  trane, tranm, tranw, m_wait
   );

   modport slave (
      input  issue_valid, issue_dst, issue_wen, issue_ismem,
      input  alu_data, mem_rdata, mem_rvalid, stall, flush,
      output trane, tranm, tranw, m_wait
   );
endinterface

// File: rtl/fwd_source.sv
// Tracks E/M/W destination, data and load flag and drives the three bypass tuples for decode.
// Latency: issue appears on trane one cycle later, then tranm and tranw one cycle apart each.
// Backpressure: stall or m_wait (load in M without data) freezes all slots; flush still clears E.
module fwd_source (
   input  logic         clk,
   input  logic         reset,
   fwd_source_if.slave  bus
);
   // Execute slot
   logic        e_vld_q, e_vld_d;
   logic [4:0]  e_dst_q, e_dst_d;
   logic        e_ismem_q, e_ismem_d;
   // Memory slot
   logic        m_vld_q, m_vld_d;
   logic [4:0]  m_dst_q, m_dst_d;
   logic        m_ismem_q, m_ismem_d;
   logic [63:0] m_data_q, m_data_d;
   logic        m_done_q, m_done_d;
   // Writeback slot
   logic        w_vld_q, w_vld_d;
   logic [4:0]  w_dst_q, w_dst_d;
   logic        w_ismem_q, w_ismem_d;
   logic [63:0] w_data_q, w_data_d;

   logic        e_wr, m_wr, w_wr;
   logic [63:0] m_fwd_data;
   logic        m_wait;
   logic        advance;

   // Slot status, M-stage data select (same-cycle load data wins over the stale value) and stall decision
   always_comb begin
      e_wr       = e_vld_q && (e_dst_q != 5'd0);
      m_wr       = m_vld_q && (m_dst_q != 5'd0);
      w_wr       = w_vld_q && (w_dst_q != 5'd0);
      m_fwd_data = m_data_q;
      if (m_ismem_q && !m_done_q && bus.mem_rvalid) begin
         m_fwd_data = bus.mem_rdata;
      end
      m_wait  = m_vld_q && m_ismem_q && !m_done_q && !bus.mem_rvalid;
      advance = !bus.stall && !m_wait;
   end

   // Bypass tuples: non-writing slots show zeros, except trane.data which is the live ALU result
   always_comb begin
      bus.trane.dst   = e_wr ? e_dst_q : 5'd0;
      bus.trane.data  = bus.alu_data;
      bus.trane.ismem = e_wr && e_ismem_q;
      bus.tranm.dst   = m_wr ? m_dst_q : 5'd0;
      bus.tranm.data  = m_wr ? m_fwd_data : 64'd0;
      bus.tranm.ismem = m_wr && m_ismem_q;
      bus.tranw.dst   = w_wr ? w_dst_q : 5'd0;
      bus.tranw.data  = w_wr ? w_data_q : 64'd0;
      bus.tranw.ismem = w_wr && w_ismem_q;
      bus.m_wait      = m_wait;
   end

   // Slot movement: shift on advance, otherwise hold while capturing late load data and honouring flush
   always_comb begin
      e_vld_d   = e_vld_q;
      e_dst_d   = e_dst_q;
      e_ismem_d = e_ismem_q;
      m_vld_d   = m_vld_q;
      m_dst_d   = m_dst_q;
      m_ismem_d = m_ismem_q;
      m_data_d  = m_data_q;
      m_done_d  = m_done_q;
      w_vld_d   = w_vld_q;
      w_dst_d   = w_dst_q;
      w_ismem_d = w_ismem_q;
      w_data_d  = w_data_q;
      if (advance) begin
         if (bus.issue_valid && !bus.flush) begin
            e_vld_d   = 1'b1;
            e_dst_d   = bus.issue_wen ? bus.issue_dst : 5'd0;
            e_ismem_d = bus.issue_ismem;
         end else begin
            e_vld_d   = 1'b0;
            e_dst_d   = 5'd0;
            e_ismem_d = 1'b0;
         end
         m_vld_d   = e_vld_q;
         m_dst_d   = e_dst_q;
         m_ismem_d = e_ismem_q;
         m_data_d  = bus.alu_data;
         m_done_d  = 1'b0;
         w_vld_d   = m_vld_q;
         w_dst_d   = m_dst_q;
         w_ismem_d = m_ismem_q;
         w_data_d  = m_fwd_data;
      end else begin
         if (m_vld_q && m_ismem_q && !m_done_q && bus.mem_rvalid) begin
            m_data_d = bus.mem_rdata;
            m_done_d = 1'b1;
         end
         if (bus.flush) begin
            e_vld_d   = 1'b0;
            e_dst_d   = 5'd0;
            e_ismem_d = 1'b0;
         end
      end
   end

   // Slot registers; reset drops every slot including any pending load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_vld_q   <= 1'b0;
         e_dst_q   <= 5'd0;
         e_ismem_q <= 1'b0;
         m_vld_q   <= 1'b0;
         m_dst_q   <= 5'd0;
         m_ismem_q <= 1'b0;
         m_data_q  <= 64'd0;
         m_done_q  <= 1'b0;
         w_vld_q   <= 1'b0;
         w_dst_q   <= 5'd0;
         w_ismem_q <= 1'b0;
         w_data_q  <= 64'd0;
      end else begin
         e_vld_q   <= e_vld_d;
         e_dst_q   <= e_dst_d;
         e_ismem_q <= e_ismem_d;
         m_vld_q   <= m_vld_d;
         m_dst_q   <= m_dst_d;
         m_ismem_q <= m_ismem_d;
         m_data_q  <= m_data_d;
         m_done_q  <= m_done_d;
         w_vld_q   <= w_vld_d;
         w_dst_q   <= w_dst_d;
         w_ismem_q <= w_ismem_d;
         w_data_q  <= w_data_d;
      end
   end
endmodule

// File: tb/tb_fwd_source.sv
// Directed bench for the bypass producer: pipeline shifting, late loads, stalls, x0, flush, async reset.
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Backpressure: stall and mem_rvalid are driven directly to exercise m_wait and slot hold.
module tb_fwd_source;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fwd_source_if bus ();

   fwd_source dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [69:0] tr(input logic [4:0] d, input logic [63:0] x, input logic m);
      return {d, x, m};
   endfunction

   task automatic idle();
      bus.issue_valid = 1'b0;
      bus.issue_dst   = 5'd0;
      bus.issue_wen   = 1'b0;
      bus.issue_ismem = 1'b0;
      bus.alu_data    = 64'd0;
      bus.mem_rdata   = 64'd0;
      bus.mem_rvalid  = 1'b0;
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] d, input logic wen, input logic ld);
      bus.issue_valid = 1'b1;
      bus.issue_dst   = d;
      bus.issue_wen   = wen;
      bus.issue_ismem = ld;
   endtask

   task automatic no_issue();
      bus.issue_valid = 1'b0;
      bus.issue_dst   = 5'd0;
      bus.issue_wen   = 1'b0;
      bus.issue_ismem = 1'b0;
   endtask

   task automatic drain();
      idle();
      repeat (3) next_cycle();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      bus.alu_data = 64'h1234;
      #2;
      checks++;
      if (bus.trane !== tr(5'd0, 64'h1234, 1'b0)) begin
         errors++; $display("FAIL reset_trane got %h want %h", bus.trane, tr(5'd0, 64'h1234, 1'b0));
      end
      checks++;
      if (bus.tranm !== tr(5'd0, 64'd0, 1'b0) || bus.tranw !== tr(5'd0, 64'd0, 1'b0) || bus.m_wait !== 1'b0) begin
         errors++; $display("FAIL reset_mw got tranm %h tranw %h m_wait %b want zeros", bus.tranm, bus.tranw, bus.m_wait);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle();
   endtask

   task automatic test_back_to_back();
      drain();
      issue(5'd5, 1'b1, 1'b0);
      next_cycle();
      issue(5'd6, 1'b1, 1'b0);
      bus.alu_data = 64'h11;
      @(negedge clk);
      checks++;
      if (bus.trane !== tr(5'd5, 64'h11, 1'b0)) begin
         errors++; $display("FAIL b2b_c1_trane got %h want %h", bus.trane, tr(5'd5, 64'h11, 1'b0));
      end
      next_cycle();
      no_issue();
      bus.alu_data = 64'h22;
      @(negedge clk);
      checks++;
      if (bus.trane !== tr(5'd6, 64'h22, 1'b0)) begin
         errors++; $display("FAIL b2b_c2_trane got %h want %h", bus.trane, tr(5'd6, 64'h22, 1'b0));
      end
      checks++;
      if (bus.tranm !== tr(5'd5, 64'h11, 1'b0)) begin
         errors++; $display("FAIL b2b_c2_tranm got %h want %h", bus.tranm, tr(5'd5, 64'h11, 1'b0));
      end
      next_cycle();
      bus.alu_data = 64'd0;
      @(negedge clk);
      checks++;
      if (bus.tranw !== tr(5'd5, 64'h11, 1'b0)) begin
         errors++; $display("FAIL b2b_c3_tranw got %h want %h", bus.tranw, tr(5'd5, 64'h11, 1'b0));
      end
      checks++;
      if (bus.tranm !== tr(5'd6, 64'h22, 1'b0) || bus.trane !== tr(5'd0, 64'd0, 1'b0)) begin
         errors++; $display("FAIL b2b_c3_em got trane %h tranm %h want %h %h", bus.trane, bus.tranm, tr(5'd0, 64'd0, 1'b0), tr(5'd6, 64'h22, 1'b0));
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus.tranw !== tr(5'd6, 64'h22, 1'b0)) begin
         errors++; $display("FAIL b2b_c4_tranw got %h want %h", bus.tranw, tr(5'd6, 64'h22, 1'b0));
      end
   endtask

   task automatic test_load_late();
      drain();
      issue(5'd7, 1'b1, 1'b1);
      next_cycle();
      no_issue();
      bus.alu_data = 64'h55;
      @(negedge clk);
      checks++;
      if (bus.trane !== tr(5'd7, 64'h55, 1'b1) || bus.m_wait !== 1'b0) begin
         errors++; $display("FAIL ld_e got trane %h m_wait %b want %h 0", bus.trane, bus.m_wait, tr(5'd7, 64'h55, 1'b1));
      end
      next_cycle();
      bus.alu_data = 64'd0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.m_wait !== 1'b1 || bus.tranm.dst !== 5'd7 || bus.tranm.ismem !== 1'b1) begin
            errors++; $display("FAIL ld_wait%0d got m_wait %b tranm %h want 1 dst 7 ismem 1", i, bus.m_wait, bus.tranm);
         end
         next_cycle();
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'hDEAD;
      @(negedge clk);
      checks++;
      if (bus.tranm !== tr(5'd7, 64'hDEAD, 1'b1) || bus.m_wait !== 1'b0) begin
         errors++; $display("FAIL ld_rvalid got tranm %h m_wait %b want %h 0", bus.tranm, bus.m_wait, tr(5'd7, 64'hDEAD, 1'b1));
      end
      next_cycle();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 64'd0;
      @(negedge clk);
      checks++;
      if (bus.tranw !== tr(5'd7, 64'hDEAD, 1'b1) || bus.tranm !== tr(5'd0, 64'd0, 1'b0)) begin
         errors++; $display("FAIL ld_wb got tranw %h tranm %h want %h zero", bus.tranw, bus.tranm, tr(5'd7, 64'hDEAD, 1'b1));
      end
   endtask

   task automatic test_load_stall();
      drain();
      issue(5'd8, 1'b1, 1'b1);
      next_cycle();
      no_issue();
      bus.alu_data = 64'h66;
      next_cycle();
      bus.alu_data   = 64'd0;
      bus.stall      = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'hBEEF;
      @(negedge clk);
      checks++;
      if (bus.m_wait !== 1'b0 || bus.tranm !== tr(5'd8, 64'hBEEF, 1'b1)) begin
         errors++; $display("FAIL lds_pulse got m_wait %b tranm %h want 0 %h", bus.m_wait, bus.tranm, tr(5'd8, 64'hBEEF, 1'b1));
      end
      next_cycle();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 64'd0;
      @(negedge clk);
      checks++;
      if (bus.m_wait !== 1'b0 || bus.tranm !== tr(5'd8, 64'hBEEF, 1'b1)) begin
         errors++; $display("FAIL lds_done got m_wait %b tranm %h want 0 %h", bus.m_wait, bus.tranm, tr(5'd8, 64'hBEEF, 1'b1));
      end
      next_cycle();
      bus.stall = 1'b0;
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus.tranw !== tr(5'd8, 64'hBEEF, 1'b1)) begin
         errors++; $display("FAIL lds_wb got tranw %h want %h", bus.tranw, tr(5'd8, 64'hBEEF, 1'b1));
      end
   endtask

   task automatic test_x0_nonwriting();
      drain();
      issue(5'd0, 1'b1, 1'b0);
      next_cycle();
      issue(5'd12, 1'b0, 1'b0);
      bus.alu_data = 64'h77;
      @(negedge clk);
      checks++;
      if (bus.trane !== tr(5'd0, 64'h77, 1'b0)) begin
         errors++; $display("FAIL x0_trane got %h want %h", bus.trane, tr(5'd0, 64'h77, 1'b0));
      end
      next_cycle();
      no_issue();
      bus.alu_data = 64'h88;
      @(negedge clk);
      checks++;
      if (bus.trane !== tr(5'd0, 64'h88, 1'b0) || bus.tranm !== tr(5'd0, 64'd0, 1'b0)) begin
         errors++; $display("FAIL nowen_em got trane %h tranm %h want %h zero", bus.trane, bus.tranm, tr(5'd0, 64'h88, 1'b0));
      end
      next_cycle();
      bus.alu_data = 64'd0;
      @(negedge clk);
      checks++;
      if (bus.tranm !== tr(5'd0, 64'd0, 1'b0) || bus.tranw !== tr(5'd0, 64'd0, 1'b0)) begin
         errors++; $display("FAIL nowen_mw got tranm %h tranw %h want zeros", bus.tranm, bus.tranw);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus.tranw !== tr(5'd0, 64'd0, 1'b0)) begin
         errors++; $display("FAIL nowen_w got tranw %h want zero", bus.tranw);
      end
   endtask

   task automatic test_flush();
      drain();
      issue(5'd3, 1'b1, 1'b0);
      next_cycle();
      issue(5'd4, 1'b1, 1'b0);
      bus.alu_data = 64'h33;
      next_cycle();
      issue(5'd9, 1'b1, 1'b0);
      bus.alu_data = 64'h44;
      bus.flush    = 1'b1;
      next_cycle();
      no_issue();
      bus.flush    = 1'b0;
      bus.alu_data = 64'd0;
      @(negedge clk);
      checks++;
      if (bus.trane.dst !== 5'd0) begin
         errors++; $display("FAIL flush_issue got trane.dst %0d want 0", bus.trane.dst);
      end
      checks++;
      if (bus.tranm !== tr(5'd4, 64'h44, 1'b0) || bus.tranw !== tr(5'd3, 64'h33, 1'b0)) begin
         errors++; $display("FAIL flush_mw got tranm %h tranw %h want %h %h", bus.tranm, bus.tranw, tr(5'd4, 64'h44, 1'b0), tr(5'd3, 64'h33, 1'b0));
      end
      issue(5'd10, 1'b1, 1'b0);
      next_cycle();
      issue(5'd11, 1'b1, 1'b0);
      bus.alu_data = 64'hA0;
      next_cycle();
      no_issue();
      bus.alu_data = 64'd0;
      bus.stall    = 1'b1;
      bus.flush    = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.trane.dst !== 5'd11) begin
         errors++; $display("FAIL flush_pre got trane.dst %0d want 11", bus.trane.dst);
      end
      next_cycle();
      bus.flush = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.trane.dst !== 5'd0 || bus.tranm !== tr(5'd10, 64'hA0, 1'b0) || bus.tranw !== tr(5'd0, 64'd0, 1'b0)) begin
         errors++; $display("FAIL flush_stall got trane.dst %0d tranm %h tranw %h want 0 %h zero", bus.trane.dst, bus.tranm, bus.tranw, tr(5'd10, 64'hA0, 1'b0));
      end
      next_cycle();
      bus.stall = 1'b0;
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus.tranw !== tr(5'd10, 64'hA0, 1'b0)) begin
         errors++; $display("FAIL flush_release got tranw %h want %h", bus.tranw, tr(5'd10, 64'hA0, 1'b0));
      end
   endtask

   task automatic test_async_reset();
      drain();
      issue(5'd13, 1'b1, 1'b1);
      next_cycle();
      no_issue();
      bus.alu_data = 64'h99;
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus.m_wait !== 1'b1 || bus.tranm.dst !== 5'd13) begin
         errors++; $display("FAIL arst_pre got m_wait %b tranm.dst %0d want 1 13", bus.m_wait, bus.tranm.dst);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.trane !== tr(5'd0, 64'h99, 1'b0) || bus.tranm !== tr(5'd0, 64'd0, 1'b0) ||
          bus.tranw !== tr(5'd0, 64'd0, 1'b0) || bus.m_wait !== 1'b0) begin
         errors++; $display("FAIL arst_now got trane %h tranm %h tranw %h m_wait %b want %h zeros", bus.trane, bus.tranm, bus.tranw, bus.m_wait, tr(5'd0, 64'h99, 1'b0));
      end
      next_cycle();
      reset = 1'b0;
      bus.alu_data = 64'd0;
      @(negedge clk);
      checks++;
      if (bus.m_wait !== 1'b0 || bus.tranm !== tr(5'd0, 64'd0, 1'b0) || bus.tranw !== tr(5'd0, 64'd0, 1'b0)) begin
         errors++; $display("FAIL arst_after got m_wait %b tranm %h tranw %h want zeros", bus.m_wait, bus.tranm, bus.tranw);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle();
      test_reset();
      test_back_to_back();
      test_load_late();
      test_load_stall();
      test_x0_nonwriting();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
